fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Multi-cycle controller that sequences instruction fetch and PC update for the MIPS-32 PC/next-PC datapath. It issues requests to an instruction memory with a request/ready/valid handshake and presents each fetched word to decode for one execute window. It generates the PC write-enable and the next-PC source select (PC+4, branch, jump, jr) from control-unit and ALU flags. It sits between the control unit/ALU and the PC register with its next-PC muxes, and it replaces the free-running PC update.

Parameters:
BOOT_CYCLES, 2, idle cycles after reset release before the first fetch (range 1..15)
TIMEOUT_CYCLES, 16, maximum FETCH_WAIT cycles before a fetch error (range 2..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
branch_control  in  1  branch instruction decoded (bne semantics)
jump_control  in  1  j instruction decoded
JR_control  in  1  jr instruction decoded
Zero_flag  in  1  ALU zero flag
dmem_busy  in  1  data memory not ready; execute must hold
halt  in  1  stop fetching after the current instruction retires
imem_ready  in  1  instruction memory accepts a request this cycle
imem_rvalid  in  1  instruction word valid on imem_rdata
imem_rdata  in  32  fetched instruction word
imem_req  out  1  fetch request
instr_out  out  32  latched instruction for decode
instr_valid  out  1  instr_out is valid (EXEC state)
pc_en  out  1  PC register write enable
pc_sel  out  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target, 11 jr
retired_cnt  out  CNT_W  count of retired instructions
fetch_error  out  1  sticky timeout flag
halted  out  1  core halted

Behaviour:
- Reset (synchronous, priority over everything, including mid-fetch): state=BOOT, boot counter=0, timeout counter=0. All outputs are 0: instr_out=0, retired_cnt=0, fetch_error=0, halted=0.
- States: BOOT, FETCH_REQ, FETCH_WAIT, EXEC, HALT, ERROR. State encoding lives in the package.
- BOOT: counter increments each cycle. When it reaches BOOT_CYCLES-1, the next state is FETCH_REQ.
- FETCH_REQ: imem_req=1. When imem_ready=1 at the clock edge, go to FETCH_WAIT. Otherwise hold; there is no timeout in this state.
- FETCH_WAIT: imem_req=0. On imem_rvalid=1: latch imem_rdata into instr_out, clear the timeout counter, go to EXEC. Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES without rvalid, go to ERROR.
- imem_rvalid is ignored in every state except FETCH_WAIT.
- EXEC: instr_valid=1.
  - If dmem_busy=1: pc_en=0 and hold EXEC. instr_out is stable.
  - If dmem_busy=0: pc_en=1 for this cycle, retired_cnt increments (wraps modulo 2^CNT_W). Next state is HALT if halt=1, else FETCH_REQ.
- pc_sel (combinational, valid whenever pc_en=1; 00 otherwise). Priority: JR_control -> 11; else jump_control -> 10; else (branch_control & ~Zero_flag) -> 01; else 00. Simultaneous control assertions resolve by this priority.
- Latency: with imem_ready and rvalid each asserted in the first eligible cycle, one instruction takes 3 cycles (FETCH_REQ, FETCH_WAIT, EXEC).
- HALT: halted=1, imem_req=0, pc_en=0. Held until reset.
- ERROR: fetch_error=1, imem_req=0, pc_en=0. Held until reset.
- instr_valid=0 outside EXEC. pc_en is high in exactly one cycle per retired instruction.

Decomposition:
- Package fetch_seq_pkg: state enum; pc_sel constants SEL_PC4=2'b00, SEL_BR=2'b01, SEL_J=2'b10, SEL_JR=2'b11.
- One sub-module, next_pc_select: the combinational priority encoder that produces pc_sel from the control flags and pc_en.
- The FSM, counters and instruction latch stay in the top module.

Test Plan:
- Reset, then memory always ready with rvalid one cycle after the request -> first imem_req at cycle BOOT_CYCLES (2). instr_valid every 3rd cycle; retired_cnt=5 after 15 cycles.
- In EXEC: branch_control=1, Zero_flag=0 -> pc_sel=01 with pc_en=1. Same with Zero_flag=1 -> pc_sel=00. JR_control=jump_control=branch_control=1 -> pc_sel=11.
- dmem_busy held for 4 cycles during EXEC -> instr_valid and instr_out (e.g. 32'h1440FFFE) stable for 5 cycles. pc_en pulses once, on the 5th cycle only. retired_cnt increments once.
- imem_ready low for 3 cycles -> imem_req stays high for 4 cycles, with no error. rvalid never arrives -> fetch_error=1 after TIMEOUT_CYCLES (16) FETCH_WAIT cycles; no further imem_req.
- halt=1 during the retiring EXEC cycle -> halted=1 on the next cycle; imem_req stays 0 for 20 cycles.
- Reset asserted in FETCH_WAIT with a stale rvalid arriving the following cycle -> all outputs 0 and state BOOT. The stale rvalid is ignored and instr_out stays 0.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and next-PC source codes.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_EXEC       = 3'd3,
    ST_HALT       = 3'd4,
    ST_ERROR      = 3'd5
  } state_t;

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

endpackage

// File: rtl/next_pc_select.sv
// Priority encoder for the next-PC mux; forced to PC+4 whenever the PC is not being written.
module next_pc_select
  import fetch_seq_pkg::*;
(
  input  logic       pc_en,
  input  logic       branch_control,
  input  logic       jump_control,
  input  logic       JR_control,
  input  logic       Zero_flag,
  output logic [1:0] pc_sel
);

  always_comb begin
    pc_sel = SEL_PC4;
    if (pc_en) begin
      if (JR_control)                       pc_sel = SEL_JR;
      else if (jump_control)                pc_sel = SEL_J;
      else if (branch_control && !Zero_flag) pc_sel = SEL_BR;
      else                                  pc_sel = SEL_PC4;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer for the MIPS-32 PC datapath: boot delay, imem
// handshake with timeout, one execute window per instruction, PC write enable and select.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int BOOT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_control,
  input  logic             jump_control,
  input  logic             JR_control,
  input  logic             Zero_flag,
  input  logic             dmem_busy,
  input  logic             halt,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             fetch_error,
  output logic             halted,
  output state_t           state_dbg
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [3:0] boot_cnt;
  logic [7:0] wait_cnt;

  // Handshake: a request is accepted on any edge where imem_req && imem_ready; the word
  // is then taken on the first edge in FETCH_WAIT with imem_rvalid, which is ignored elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      boot_cnt    <= 4'd0;
      wait_cnt    <= 8'd0;
      instr_out   <= 32'd0;
      retired_cnt <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) state <= ST_FETCH_REQ;
          else                       boot_cnt <= boot_cnt + 4'd1;
        end
        ST_FETCH_REQ: begin
          if (imem_ready) state <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          if (imem_rvalid) begin
            instr_out <= imem_rdata;
            wait_cnt  <= 8'd0;
            state     <= ST_EXEC;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) state <= ST_ERROR;
          end
        end
        ST_EXEC: begin
          if (!dmem_busy) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= halt ? ST_HALT : ST_FETCH_REQ;
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_BOOT;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register; only pc_en sees dmem_busy.
  assign imem_req    = (state == ST_FETCH_REQ);
  assign instr_valid = (state == ST_EXEC);
  assign pc_en       = (state == ST_EXEC) && !dmem_busy;
  assign halted      = (state == ST_HALT);
  assign fetch_error = (state == ST_ERROR);
  assign state_dbg   = state;

  next_pc_select u_next_pc_select (
    .pc_en          (pc_en),
    .branch_control (branch_control),
    .jump_control   (jump_control),
    .JR_control     (JR_control),
    .Zero_flag      (Zero_flag),
    .pc_sel         (pc_sel)
  );

endmodule
